// File: rtl/iq_quant_decim.sv
// iq_quant_decim: integrate-and-dump decimator with adaptive 2-bit I/Q quantizer feeding a correlator shift register.
//   clk_i        rising-edge clock
//   rst_n_i      asynchronous active-low reset
//   clr_i        sync clear of partial sums, decim/window/hit counts (threshold kept)
//   in_valid_i   in_i_i/in_q_i qualify this cycle
//   in_i_i/in_q_i  signed IN_WIDTH samples
//   we_o         one-cycle write strobe per dump
//   wdata_o      {I_sign, I_mag, Q_sign, Q_mag}
//   thr_o        current magnitude threshold
// Build option: define IQQ_FIXED_THRESH_EN to drop adaptation and hold the threshold at THR_INIT.
module iq_quant_decim #(
    parameter int IN_WIDTH  = 12,
    parameter int DECIM     = 4,
    parameter int ACC_W     = IN_WIDTH + $clog2(DECIM),
    parameter int THR_INIT  = 2048,
    parameter int WIN_LEN   = 256,
    parameter int TARGET_HI = 171,
    parameter int HYST      = 16,
    parameter int THR_STEP  = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       clr_i,
    input  logic                       in_valid_i,
    input  logic signed [IN_WIDTH-1:0] in_i_i,
    input  logic signed [IN_WIDTH-1:0] in_q_i,
    output logic                       we_o,
    output logic [3:0]                 wdata_o,
    output logic [ACC_W-1:0]           thr_o
);
    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(DECIM - 1);
    logic signed [ACC_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d, sum_i, sum_q;
    logic [ACC_W:0] abs_i, abs_q;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic we_q, we_d, dump, mag_i, mag_q;
    logic [3:0] wdata_q, wdata_d;
    logic [ACC_W-1:0] thr;
    // Sums include the current sample so the dump sees all DECIM samples; CLR drops the sample.
    always_comb begin
        sum_i   = acc_i_q + ACC_W'(in_i_i);
        sum_q   = acc_q_q + ACC_W'(in_q_i);
        dump    = in_valid_i && !clr_i && dcnt_q == D_LAST;
        // One extra bit so negating the most-negative sum cannot wrap.
        abs_i   = sum_i[ACC_W-1] ? -(ACC_W+1)'(sum_i) : (ACC_W+1)'(sum_i);
        abs_q   = sum_q[ACC_W-1] ? -(ACC_W+1)'(sum_q) : (ACC_W+1)'(sum_q);
        mag_i   = abs_i >= {1'b0, thr};
        mag_q   = abs_q >= {1'b0, thr};
        acc_i_d = (clr_i || dump) ? '0 : in_valid_i ? sum_i : acc_i_q;
        acc_q_d = (clr_i || dump) ? '0 : in_valid_i ? sum_q : acc_q_q;
        dcnt_d  = (clr_i || dump) ? '0 : in_valid_i ? dcnt_q + DW'(1) : dcnt_q;
        we_d    = dump;
        wdata_d = dump ? {sum_i[ACC_W-1], mag_i, sum_q[ACC_W-1], mag_q} : wdata_q;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_i_q <= '0;
            acc_q_q <= '0;
            dcnt_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
            dcnt_q  <= dcnt_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end
`ifdef IQQ_FIXED_THRESH_EN
    assign thr = ACC_W'(THR_INIT);
`else
    localparam int HW = $clog2(2 * WIN_LEN + 1);
    localparam int WW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [WW-1:0] W_LAST = WW'(WIN_LEN - 1);
    localparam logic [HW-1:0] HI_LIM = HW'(TARGET_HI + HYST);
    localparam logic [HW-1:0] LO_LIM = HW'(TARGET_HI - HYST);
    localparam logic [ACC_W:0] STEP = (ACC_W+1)'(THR_STEP);
    localparam logic [ACC_W-1:0] THR_MAX = '1;
    logic [ACC_W-1:0] thr_q, thr_d;
    logic [HW-1:0] hits_q, hits_d, hits_sum;
    logic [WW-1:0] win_q, win_d;
    logic [ACC_W:0] thr_up;
    logic win_end;
    // The closing dump's own mag bits count toward its window's decision.
    always_comb begin
        hits_sum = hits_q + HW'(mag_i) + HW'(mag_q);
        win_end  = dump && win_q == W_LAST;
        thr_up   = {1'b0, thr_q} + STEP;
        thr_d    = thr_q;
        if (win_end && hits_sum > HI_LIM)
            thr_d = thr_up[ACC_W] ? THR_MAX : thr_up[ACC_W-1:0];
        else if (win_end && hits_sum < LO_LIM)
            thr_d = ({1'b0, thr_q} > STEP) ? thr_q - STEP[ACC_W-1:0] : ACC_W'(1);
        hits_d   = (clr_i || win_end) ? '0 : dump ? hits_sum : hits_q;
        win_d    = (clr_i || win_end) ? '0 : dump ? win_q + WW'(1) : win_q;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            thr_q  <= ACC_W'(THR_INIT);
            hits_q <= '0;
            win_q  <= '0;
        end else begin
            thr_q  <= thr_d;
            hits_q <= hits_d;
            win_q  <= win_d;
        end
    end
    assign thr = thr_q;
`endif
    assign we_o    = we_q;
    assign wdata_o = wdata_q;
    assign thr_o   = thr;
endmodule
